// File: rtl/cb_cfg_pkg.sv
// Shared types and index helpers for the connection-block configuration loader.
package cb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Number of IN_W-bit words needed to carry cfg_bits bits (rounded up).
  function automatic int calc_nwords(input int cfg_bits, input int in_w);
    return (cfg_bits + in_w - 1) / in_w;
  endfunction

  // Position of the enable that connects data output i to track j. Output
  // enables sit above the DATAIN*W input enables, one W-bit group per output.
  function automatic int out_sel_bit(input int i, input int j, input int w, input int datain);
    return j + i * w + datain * w;
  endfunction

endpackage

// File: rtl/cb_track_checker.sv
// Combinational contention check for one routing track: flags the track when
// more than one data output is enabled onto it.
module cb_track_checker
  import cb_cfg_pkg::*;
#(
  parameter int W       = 16,
  parameter int DATAIN  = 3,
  parameter int DATAOUT = 2
) (
  input  logic [W*(DATAIN+DATAOUT)-1:0] shadow_i,
  input  logic [$clog2(W)-1:0]          track_i,
  output logic                          contention_o
);

  localparam int CFG_BITS = W * (DATAIN + DATAOUT);
  localparam int IDX_W    = $clog2(CFG_BITS);
  localparam int CNT_W    = $clog2(DATAOUT + 1);

  logic [CNT_W-1:0] drv_cnt;
  logic [IDX_W-1:0] bit_idx;

  // Count the output drivers enabled onto the selected track.
  always_comb begin
    drv_cnt = '0;
    bit_idx = '0;
    for (int i = 0; i < DATAOUT; i++) begin
      bit_idx = IDX_W'(out_sel_bit(i, int'(track_i), W, DATAIN));
      drv_cnt = drv_cnt + CNT_W'(shadow_i[bit_idx]);
    end
    contention_o = (drv_cnt > CNT_W'(1));
  end

endmodule

// File: rtl/cb_config_loader.sv
// Configuration loader for a data connection block. Streams the switch-enable
// vector into a shadow register, scans every track for multiple output
// drivers, and only then copies the shadow onto the live c bus in one edge.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; c holds the last committed vector
//   ST_LOAD   | accepting configuration words into the shadow register
//   ST_CHECK  | examining one track per cycle for output contention
//   ST_COMMIT | copying the shadow to c; done pulses on the following cycle
//   ST_ERROR  | contention found; err sticky until the next start
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int W       = 16,
  parameter int DATAIN  = 3,
  parameter int DATAOUT = 2,
  parameter int IN_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [IN_W-1:0]               cfg_data,
  output logic [W*(DATAIN+DATAOUT)-1:0] c,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(W)-1:0]          err_track
);

  localparam int CFG_BITS = W * (DATAIN + DATAOUT);
  localparam int NWORDS   = calc_nwords(CFG_BITS, IN_W);
  localparam int WC_W     = $clog2(NWORDS);
  localparam int TW       = $clog2(W);
  localparam int SB_W     = $clog2(CFG_BITS);

  state_e              state_q;
  logic [WC_W-1:0]     wcnt_q;
  logic [TW-1:0]       tcnt_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] shadow_d;
  logic [CFG_BITS-1:0] c_q;
  logic                done_q;
  logic                err_q;
  logic [TW-1:0]       err_track_q;
  logic                contention;

  cb_track_checker #(
    .W       (W),
    .DATAIN  (DATAIN),
    .DATAOUT (DATAOUT)
  ) u_track_checker (
    .shadow_i     (shadow_q),
    .track_i      (tcnt_q),
    .contention_o (contention)
  );

  // Shadow write: an accepted word lands at its word slot; bits past the
  // end of the vector are dropped, and a word that coincides with abort is lost.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == ST_LOAD && cfg_valid && !abort) begin
      for (int b = 0; b < IN_W; b++) begin
        if ((int'(wcnt_q) * IN_W + b) < CFG_BITS)
          shadow_d[SB_W'(int'(wcnt_q) * IN_W + b)] = cfg_data[b];
      end
    end
  end

  // Sequencer: state, counters, shadow, live vector and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      shadow_q    <= '0;
      c_q         <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_track_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            wcnt_q  <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (cfg_valid) begin
            if (wcnt_q == WC_W'(NWORDS - 1)) begin
              state_q <= ST_CHECK;
              tcnt_q  <= '0;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (contention) begin
            state_q     <= ST_ERROR;
            err_q       <= 1'b1;
            err_track_q <= tcnt_q;
          end else if (tcnt_q == TW'(W - 1)) begin
            state_q <= ST_COMMIT;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          c_q     <= shadow_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          if (start) begin
            state_q     <= ST_LOAD;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            err_track_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_COMMIT);
  assign c         = c_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_track = err_track_q;

endmodule

// File: tb/tb_cb_config_loader.sv
// Scoreboard bench for cb_config_loader: stimulus pushes the expected
// commit/error event, a negedge monitor pops and compares when it appears.
module tb_cb_config_loader;

  typedef logic [7:0] words_t [10];
  typedef struct {
    bit          is_err;
    logic [79:0] cval;
    logic [3:0]  trk;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_data = 8'h00;
  logic [79:0] c;
  logic        busy, done, err;
  logic [3:0]  err_track;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   hs_cnt = 0;
  exp_t exp_q[$];
  exp_t ev;
  logic err_d = 1'b0;

  words_t clean_w = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
  words_t bad_w   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00};
  words_t bp_w    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h0F, 8'h00, 8'hF0, 8'hFF};

  // Hand-derived: only bit 48 (out0, track 0) and bit 65 (out1, track 1).
  localparam logic [79:0] CLEAN_C = (80'd1 << 48) | (80'd1 << 65);

  cb_config_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_track (err_track)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!rst && cfg_valid && cfg_ready && !abort) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [79:0] model_c(input words_t w);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k*8 +: 8] = w[k];
    return r;
  endfunction

  task automatic push_exp(input bit is_err, input logic [79:0] cval, input logic [3:0] trk, input int lat);
    exp_t e;
    e.is_err = is_err;
    e.cval   = cval;
    e.trk    = trk;
    e.lat    = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse or rising err is matched against the queue.
  always @(negedge clk) begin
    if (rst) begin
      err_d = 1'b0;
    end else begin
      if (done || (err && !err_d)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: done=%0b err=%0b with nothing expected", done, err);
        end else begin
          ev = exp_q.pop_front();
          chk("event_kind_err", {79'd0, err}, {79'd0, ev.is_err});
          chk("event_done", {79'd0, done}, {79'd0, !ev.is_err});
          chk("c_value", c, ev.cval);
          if (ev.is_err) chk("err_track", {76'd0, err_track}, {76'd0, ev.trk});
          if (ev.lat > 0) chk("latency", 80'(cyc - start_cyc), 80'(ev.lat));
        end
      end
      err_d = err;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL event_timeout: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_load(input words_t w, input bit toggle, input int abort_after, output int hs);
    int  hs0;
    bit  got;
    hs0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_ready_rise", {79'd0, cfg_ready}, 80'd1);
    chk("err_clear_on_load", {79'd0, err}, 80'd0);
    for (int k = 0; k < 10; k++) begin
      if (toggle && k > 0) begin
        cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
      cfg_valid = 1'b1;
      cfg_data  = w[k];
      if (k == abort_after) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        cfg_valid = 1'b0;
        hs = hs_cnt - hs0;
        return;
      end
      got = 1'b0;
      for (int g = 0; g < 20 && !got; g++) begin
        @(negedge clk);
        got = cfg_ready;
        @(posedge clk); #1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: word %0d not accepted, expected acceptance", k);
        cfg_valid = 1'b0;
        hs = hs_cnt - hs0;
        return;
      end
    end
    cfg_valid = 1'b0;
    hs = hs_cnt - hs0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    #12;
    chk("rst_c", c, 80'd0);
    chk("rst_cfg_ready", {79'd0, cfg_ready}, 80'd0);
    chk("rst_busy", {79'd0, busy}, 80'd0);
    chk("rst_done", {79'd0, done}, 80'd0);
    chk("rst_err", {79'd0, err}, 80'd0);
    chk("rst_err_track", {76'd0, err_track}, 80'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean load: commit 28 cycles after start is raised.
    push_exp(1'b0, CLEAN_C, 4'd0, 28);
    run_load(clean_w, 1'b0, -1, hs);
    wait_drain();
    chk("clean_handshakes", 80'(hs), 80'd10);
    chk("clean_idle_busy", {79'd0, busy}, 80'd0);

    // Contention on track 5: error at 1+10+5+1 = 17, c keeps the clean value.
    push_exp(1'b1, CLEAN_C, 4'd5, 17);
    run_load(bad_w, 1'b0, -1, hs);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", {79'd0, err}, 80'd1);
    chk("err_busy_low", {79'd0, busy}, 80'd0);
    chk("err_c_held", c, CLEAN_C);

    // Recovery from ERROR with the clean stream.
    push_exp(1'b0, CLEAN_C, 4'd0, 28);
    run_load(clean_w, 1'b0, -1, hs);
    wait_drain();
    chk("recover_err", {79'd0, err}, 80'd0);

    // Backpressure: gaps between words; shadow must carry all 10 in order.
    push_exp(1'b0, model_c(bp_w), 4'd0, -1);
    run_load(bp_w, 1'b1, -1, hs);
    wait_drain();
    chk("bp_handshakes", 80'(hs), 80'd10);

    // Abort while presenting word 4: idle next cycle, c unchanged.
    run_load(clean_w, 1'b0, 4, hs);
    chk("abort_busy", {79'd0, busy}, 80'd0);
    chk("abort_cfg_ready", {79'd0, cfg_ready}, 80'd0);
    chk("abort_c_held", c, model_c(bp_w));
    chk("abort_handshakes", 80'(hs), 80'd4);
    repeat (3) @(posedge clk);
    push_exp(1'b0, CLEAN_C, 4'd0, 28);
    run_load(clean_w, 1'b0, -1, hs);
    wait_drain();

    // Asynchronous reset mid-LOAD.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'h55;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", {79'd0, busy}, 80'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_c", c, 80'd0);
    chk("async_rst_cfg_ready", {79'd0, cfg_ready}, 80'd0);
    chk("async_rst_busy", {79'd0, busy}, 80'd0);
    chk("async_rst_err", {79'd0, err}, 80'd0);
    cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {79'd0, busy}, 80'd0);
    chk("post_rst_c", c, 80'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
